decode_in_issue_queue: RTL

- Synthesizable, parametrised issue engine for the decode-stage input bus (enable_decode / dout / npc_in).
- Buffers instruction/NPC pairs in a FIFO and replays them as enable_decode pulses, with programmable hold and gap timing.
- Used as the hardware-side stimulus source in emulation and system benches. Replaces the fixed-timing procedural drive with a configurable, back-pressured stream.

---
 rtl/decode_in_issue_queue.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_in_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_in_issue_queue
//  Description : Buffers instruction/NPC pairs and replays them on the decode
//                input bus as enable_decode pulses with programmable hold/gap.
//                Optional macro DECODE_IN_ISSUE_AUTO_NPC_EN: NPC comes from an
//                internal incrementing register instead of the FIFO entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_in_issue_queue #(
    parameter int                 INSTR_W  = 16,
    parameter int                 ADDR_W   = 16,
    parameter int                 DEPTH    = 8,
    parameter int                 CNT_W    = 4,
    parameter logic [INSTR_W-1:0] DOUT_RST = 16'h5020,
    parameter logic [ADDR_W-1:0]  NPC_RST  = 16'h3001
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [INSTR_W-1:0]       in_instr_i,
    input  logic [ADDR_W-1:0]        in_npc_i,
    input  logic [CNT_W-1:0]         hold_i,
    input  logic [CNT_W-1:0]         gap_i,
    input  logic                     stall_i,
    output logic                     enable_decode_o,
    output logic [INSTR_W-1:0]       dout_o,
    output logic [ADDR_W-1:0]        npc_in_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [31:0]              issued_count_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_DRIVE = 2'd1;
    localparam logic [1:0] c_S_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic               w_full;
    logic               w_empty;
    logic               w_push;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_hold_eff;
    logic               w_issue;
    logic               w_drop;
    logic               w_load_gap;

    logic               r_en;
    logic [INSTR_W-1:0] r_dout;
    logic [ADDR_W-1:0]  r_npc;
    logic [31:0]        r_issued;

    // Full when the pointers alias the same slot but differ by one lap.
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = in_valid_i && !w_full;

    assign w_hold_eff = (hold_i == '0) ? c_CNT_ONE : hold_i;

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr[c_AW-1:0]] <= in_instr_i;
        end
    end

`ifdef DECODE_IN_ISSUE_AUTO_NPC_EN
    logic [ADDR_W-1:0] r_auto_npc;
    logic              w_unused_npc;

    assign w_unused_npc = ^in_npc_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_auto_npc <= NPC_RST;
        end else if (w_issue) begin
            r_auto_npc <= r_auto_npc + 1'b1;
        end
    end

    logic [ADDR_W-1:0] w_head_npc;
    assign w_head_npc = r_auto_npc;
`else
    logic [ADDR_W-1:0] r_mem_npc [DEPTH];

    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_mem_npc[r_wr_ptr[c_AW-1:0]] <= in_npc_i;
        end
    end

    logic [ADDR_W-1:0] w_head_npc;
    assign w_head_npc = r_mem_npc[r_rd_ptr[c_AW-1:0]];
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (!w_empty && !stall_i) begin
                    w_state_next = c_S_DRIVE;
                end
            end
            c_S_DRIVE: begin
                if (r_cnt == c_CNT_ONE) begin
                    if (gap_i == '0) begin
                        if (w_empty || stall_i) begin
                            w_state_next = c_S_IDLE;
                        end
                    end else begin
                        w_state_next = c_S_GAP;
                    end
                end
            end
            c_S_GAP: begin
                if (r_cnt == c_CNT_ONE) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // Back-to-back reload only when no gap is requested, so the enable never dips.
    always_comb begin
        w_issue    = 1'b0;
        w_drop     = 1'b0;
        w_load_gap = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                w_issue = !w_empty && !stall_i;
            end
            c_S_DRIVE: begin
                if (r_cnt == c_CNT_ONE) begin
                    if ((gap_i == '0) && !w_empty && !stall_i) begin
                        w_issue = 1'b1;
                    end else begin
                        w_drop     = 1'b1;
                        w_load_gap = (gap_i != '0);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_en     <= 1'b0;
            r_dout   <= DOUT_RST;
            r_npc    <= NPC_RST;
            r_issued <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_dout   <= r_mem_instr[r_rd_ptr[c_AW-1:0]];
                r_npc    <= w_head_npc;
                r_en     <= 1'b1;
                r_cnt    <= w_hold_eff;
                r_issued <= r_issued + 32'd1;
            end else if (w_load_gap) begin
                r_en  <= 1'b0;
                r_cnt <= gap_i;
            end else begin
                if (w_drop) begin
                    r_en <= 1'b0;
                end
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign in_ready_o      = !w_full;
    assign level_o         = r_wr_ptr - r_rd_ptr;
    assign enable_decode_o = r_en;
    assign dout_o          = r_dout;
    assign npc_in_o        = r_npc;
    assign busy_o          = (r_state != c_S_IDLE);
    assign issued_count_o  = r_issued;

endmodule
`default_nettype wire
